// File: rtl/matrix_input_ctrl.sv
// matrix_input_ctrl
//   Front end for a small matrix store. A session is opened by `start`. The
//   block then takes a row-count byte and a column-count byte from the serial
//   receiver, validates both (1..MAX_DIM), opens storage with a one-cycle
//   `wen`, and forwards m*n element bytes as `elem_valid`/`elem_in` strobes.
//   The session ends when storage answers with `input_done`.
//
//   Optional feature (macro MATRIX_INPUT_PAD_EN): if no byte arrives for
//   TIMEOUT_CYCLES cycles while elements are still outstanding, the rest of
//   the matrix is filled with zero elements on consecutive cycles. Without the
//   macro, the block waits indefinitely for all m*n bytes.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   one-cycle session request (honoured only when idle)
//   rx_data    in   received byte
//   rx_valid   in   one-cycle strobe qualifying rx_data
//   input_done in   storage pulse: last element written
//   wen        out  one-cycle storage write-open pulse
//   m, n       out  latched row / column counts
//   elem_in    out  element to storage (holds when elem_valid is low)
//   elem_valid out  one-cycle strobe qualifying elem_in
//   busy       out  high whenever a session is in progress
//   done       out  one-cycle pulse on session completion
//   err_dim    out  one-cycle pulse on an illegal dimension
module matrix_input_ctrl #(
  parameter int unsigned MAX_DIM        = 5,
  parameter int unsigned ELEM_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  input_done,
  output logic                  wen,
  output logic [3:0]            m,
  output logic [3:0]            n,
  output logic [ELEM_WIDTH-1:0] elem_in,
  output logic                  elem_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err_dim
);

`ifdef MATRIX_INPUT_PAD_EN
  typedef enum logic [2:0] {
    IDLE, GET_M, GET_N, OPEN, DATA, PAD, WAIT_DONE
  } state_e;

  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(TIMEOUT_CYCLES);

  logic [IDLE_W-1:0] idle_q, idle_d;
`else
  typedef enum logic [2:0] {
    IDLE, GET_M, GET_N, OPEN, DATA, WAIT_DONE
  } state_e;
`endif

  localparam logic [3:0] MAX_D = 4'(MAX_DIM);

  state_e                state_q, state_d;
  logic [3:0]            m_q, m_d;
  logic [3:0]            n_q, n_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [ELEM_WIDTH-1:0] elem_q, elem_d;
  logic                  wen_q, wen_d;
  logic                  ev_q, ev_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [4:0]            mn;

  // Operands widened before multiplying so 5x5 yields 25, not a 4-bit wrap.
  assign mn = {1'b0, m_q} * {1'b0, n_q};

  function automatic logic dim_ok(input logic [3:0] d);
    return (d != 4'd0) && (d <= MAX_D);
  endfunction

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    n_d     = n_q;
    cnt_d   = cnt_q;
    elem_d  = elem_q;
    wen_d   = 1'b0;
    ev_d    = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef MATRIX_INPUT_PAD_EN
    idle_d  = idle_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = GET_M;
          cnt_d   = '0;
        end
      end

      GET_M: begin
        if (rx_valid) begin
          m_d     = rx_data[3:0];
          state_d = GET_N;
        end
      end

      GET_N: begin
        if (rx_valid) begin
          n_d = rx_data[3:0];
          if (dim_ok(m_q) && dim_ok(rx_data[3:0])) begin
            state_d = OPEN;
            wen_d   = 1'b1;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
      end

      // A byte landing here is captured straight into the element register,
      // so it appears on the first DATA cycle, after wen has already dropped.
      OPEN: begin
        state_d = DATA;
        cnt_d   = '0;
`ifdef MATRIX_INPUT_PAD_EN
        idle_d  = '0;
`endif
        if (rx_valid) begin
          elem_d = ELEM_WIDTH'(rx_data);
          ev_d   = 1'b1;
          cnt_d  = 5'd1;
        end
      end

      // The count==mn test covers the case where the OPEN-cycle byte alone
      // completed a 1x1 matrix.
      DATA: begin
        if (cnt_q == mn) begin
          state_d = WAIT_DONE;
        end else if (rx_valid) begin
          elem_d = ELEM_WIDTH'(rx_data);
          ev_d   = 1'b1;
          cnt_d  = cnt_q + 5'd1;
`ifdef MATRIX_INPUT_PAD_EN
          idle_d = '0;
`endif
          if (cnt_d == mn) state_d = WAIT_DONE;
        end
`ifdef MATRIX_INPUT_PAD_EN
        else if (idle_q == IDLE_MAX) begin
          state_d = PAD;
        end else begin
          idle_d = idle_q + 1'b1;
        end
`endif
      end

`ifdef MATRIX_INPUT_PAD_EN
      PAD: begin
        if (cnt_q == mn) begin
          state_d = WAIT_DONE;
        end else begin
          elem_d = '0;
          ev_d   = 1'b1;
          cnt_d  = cnt_q + 5'd1;
          if (cnt_d == mn) state_d = WAIT_DONE;
        end
      end
`endif

      WAIT_DONE: begin
        if (input_done) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      elem_q  <= '0;
      wen_q   <= 1'b0;
      ev_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MATRIX_INPUT_PAD_EN
      idle_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      n_q     <= n_d;
      cnt_q   <= cnt_d;
      elem_q  <= elem_d;
      wen_q   <= wen_d;
      ev_q    <= ev_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef MATRIX_INPUT_PAD_EN
      idle_q  <= idle_d;
`endif
    end
  end

  assign wen        = wen_q;
  assign m          = m_q;
  assign n          = n_q;
  assign elem_in    = elem_q;
  assign elem_valid = ev_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err_dim    = err_q;

endmodule

// File: tb/tb_matrix_input_ctrl.sv
// Directed bench for matrix_input_ctrl. Element bytes are pushed to a
// scoreboard when driven; a negedge monitor pops and compares on each
// elem_valid strobe. Define MATRIX_INPUT_PAD_EN to include the padding step.
module tb_matrix_input_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       input_done;
  logic       wen;
  logic [3:0] m;
  logic [3:0] n;
  logic [7:0] elem_in;
  logic       elem_valid;
  logic       busy;
  logic       done;
  logic       err_dim;

  int compared   = 0;
  int mismatched = 0;
  int wen_cnt    = 0;
  int cyc_n      = 0;
  logic [7:0] sb[$];
  int         ev_cyc[$];

  matrix_input_ctrl #(
    .MAX_DIM        (5),
    .ELEM_WIDTH     (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .input_done (input_done),
    .wen        (wen),
    .m          (m),
    .n          (n),
    .elem_in    (elem_in),
    .elem_valid (elem_valid),
    .busy       (busy),
    .done       (done),
    .err_dim    (err_dim)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (wen) begin
      wen_cnt++;
      compared++;
      assert (elem_valid === 1'b0) else begin
        mismatched++;
        $error("FAIL wen_overlap: elem_valid=%0b with wen high, want 0", elem_valid);
      end
    end
    if (elem_valid === 1'b1) begin
      ev_cyc.push_back(cyc_n);
      compared++;
      assert (sb.size() > 0) else begin
        mismatched++;
        $error("FAIL unexpected_elem: got elem_in=%0d, want no element", elem_in);
      end
      if (sb.size() > 0) begin
        logic [7:0] exp_v;
        exp_v = sb.pop_front();
        compared++;
        assert (elem_in === exp_v) else begin
          mismatched++;
          $error("FAIL elem_data: got %0d want %0d", elem_in, exp_v);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    cyc();
    rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (sb.size() != 0 && k < budget) begin
      cyc();
      k++;
    end
    cyc();
    check(tag, sb.size(), 0);
  endtask

  task automatic finish_session(input string tag);
    input_done = 1'b1;
    cyc();
    input_done = 1'b0;
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_idle"}, busy, 1'b0);
    cyc();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    int w0;
    rst_n      = 1'b0;
    start      = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    input_done = 1'b0;
    cyc();
    cyc();
    check("rst_outputs", {wen, m, n, elem_in, elem_valid, busy, done, err_dim}, '0);
    rst_n = 1'b1;
    cyc();

    // 2x3 session, elements 1..6 sent back-to-back (first lands in OPEN).
    w0 = wen_cnt;
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    send(8'd2);
    send(8'd3);
    check("wen_open", wen, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      sb.push_back(8'(i));
      send(8'(i));
    end
    drain("s23_drain", 10);
    check("s23_wen_count", wen_cnt - w0, 1);
    check("s23_m", m, 4'd2);
    check("s23_n", n, 4'd3);
    check("elem_hold", elem_in, 8'd6);
    send(8'd99);
    cyc();
    check("wait_ignores_rx", sb.size(), 0);
    finish_session("s23");

    // Illegal dimensions: m too large, m zero, n too large.
    w0 = wen_cnt;
    pulse_start();
    send(8'd6);
    send(8'd2);
    check("err_m6", err_dim, 1'b1);
    check("err_m6_idle", busy, 1'b0);
    cyc();
    check("err_pulse", err_dim, 1'b0);
    pulse_start();
    send(8'd0);
    send(8'd3);
    check("err_m0", err_dim, 1'b1);
    cyc();
    pulse_start();
    send(8'd5);
    send(8'd6);
    check("err_n6", err_dim, 1'b1);
    cyc();
    check("err_no_wen", wen_cnt - w0, 0);

    // rx_valid ignored while idle.
    send(8'd4);
    cyc();
    check("idle_ignores_rx", busy, 1'b0);

    // 1x1 with the byte in the OPEN cycle; a second byte is ignored.
    pulse_start();
    send(8'd1);
    send(8'd1);
    sb.push_back(8'd7);
    send(8'd7);
    check("open_byte_valid", elem_valid, 1'b1);
    check("open_byte_data", elem_in, 8'd7);
    send(8'd8);
    cyc();
    drain("s11_drain", 5);
    finish_session("s11");

    // 5x5 boundary: 25 elements required.
    pulse_start();
    send(8'd5);
    send(8'd5);
    for (int i = 0; i < 25; i++) begin
      sb.push_back(8'(10 + i));
      send(8'(10 + i));
    end
    drain("s55_drain", 10);
    check("s55_busy", busy, 1'b1);
    finish_session("s55");

    // start during DATA is ignored.
    pulse_start();
    send(8'd2);
    send(8'd2);
    cyc();
    sb.push_back(8'd21);
    send(8'd21);
    sb.push_back(8'd22);
    send(8'd22);
    pulse_start();
    sb.push_back(8'd23);
    send(8'd23);
    sb.push_back(8'd24);
    send(8'd24);
    drain("s22_drain", 10);
    check("s22_m", m, 4'd2);
    check("s22_n", n, 4'd2);
    finish_session("s22");

    // Reset mid-DATA of a 3x3 session, then a clean 1x1 session.
    pulse_start();
    send(8'd3);
    send(8'd3);
    cyc();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(8'(40 + i));
      send(8'(40 + i));
    end
    drain("s33_drain", 5);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {wen, m, n, elem_in, elem_valid, busy, done, err_dim}, '0);
    cyc();
    check("midrst_hold", {wen, elem_valid, busy}, '0);
    rst_n = 1'b1;
    cyc();
    pulse_start();
    send(8'd1);
    send(8'd1);
    cyc();
    sb.push_back(8'd5);
    send(8'd5);
    drain("post_rst_drain", 5);
    check("post_rst_m", m, 4'd1);
    finish_session("post_rst");

`ifdef MATRIX_INPUT_PAD_EN
    // 2x2, one byte, then silence: three zero elements back-to-back.
    pulse_start();
    send(8'd2);
    send(8'd2);
    ev_cyc.delete();
    sb.push_back(8'd9);
    send(8'd9);
    sb.push_back(8'd0);
    sb.push_back(8'd0);
    sb.push_back(8'd0);
    drain("pad_drain", 60);
    check("pad_count", ev_cyc.size(), 4);
    if (ev_cyc.size() == 4) begin
      check("pad_consec1", ev_cyc[2] - ev_cyc[1], 1);
      check("pad_consec2", ev_cyc[3] - ev_cyc[2], 1);
      check("pad_gap", (ev_cyc[1] - ev_cyc[0]) > 20, 1'b1);
    end
    send(8'd77);
    cyc();
    check("pad_wait_busy", busy, 1'b1);
    finish_session("pad");
`endif

    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/matrix_input_ctrl.md
MATRIX_INPUT_CTRL -- requirements
Module: matrix_input_ctrl

Interface
REQ-001 Parameter MAX_DIM, 5, largest legal row/column count.
REQ-002 Parameter ELEM_WIDTH, 8, element width in bits.
REQ-003 Parameter TIMEOUT_CYCLES, 50000000, idle cycles after the last byte before zero-padding starts.
REQ-004 clk  in  1  single clock; all logic on the rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  one-cycle request to open an input session.
REQ-007 rx_data  in  8  received byte, binary value.
REQ-008 rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-009 input_done  in  1  storage pulse: last element written.
REQ-010 wen  out  1  one-cycle storage write-open pulse.
REQ-011 m  out  4  latched row count.
REQ-012 n  out  4  latched column count.
REQ-013 elem_in  out  ELEM_WIDTH  element to storage.
REQ-014 elem_valid  out  1  one-cycle strobe qualifying elem_in.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse on session completion.
REQ-017 err_dim  out  1  one-cycle pulse on an illegal dimension.

Function
REQ-018 The block SHALL be a state machine with states IDLE, GET_M, GET_N, OPEN, DATA, PAD and WAIT_DONE.
REQ-019 IDLE SHALL go to GET_M on start and SHALL ignore rx_valid; start outside IDLE SHALL be ignored.
REQ-020 GET_M SHALL latch rx_data[3:0] into m on rx_valid, then go to GET_N.
REQ-021 GET_N SHALL latch n on rx_valid and check both dimensions against 1..MAX_DIM.
REQ-022 If the check fails, the block SHALL pulse err_dim for one cycle and go to IDLE.
REQ-023 If the check passes, the block SHALL go to OPEN.
REQ-024 OPEN SHALL last exactly one cycle with wen=1; elem_valid SHALL never be high while wen is high.
REQ-025 A byte arriving during OPEN SHALL be held in a one-entry register and emitted on the first DATA cycle.
REQ-026 In DATA, each rx_valid SHALL produce elem_valid=1 with elem_in=rx_data on the following cycle (latency 1) and SHALL increment a 5-bit element count.
REQ-027 When the count reaches m*n, the block SHALL go to WAIT_DONE.
REQ-028 Bytes received in WAIT_DONE SHALL be ignored.
REQ-029 The idle counter SHALL clear on every accepted byte and on entry to DATA.
REQ-030 In DATA, when the idle counter reaches TIMEOUT_CYCLES, the block SHALL go to PAD.
REQ-031 In PAD, the block SHALL emit elem_valid=1 with elem_in=0 on consecutive cycles until the count reaches m*n, then go to WAIT_DONE.
REQ-032 rx_valid SHALL be ignored in PAD.
REQ-033 WAIT_DONE SHALL, on input_done=1, pulse done on the next cycle and go to IDLE.
REQ-034 m and n SHALL hold their values until the next GET_M/GET_N capture.
REQ-035 elem_in SHALL hold its last value when elem_valid=0.
REQ-036 m*n SHALL be computed in at least 5 bits; a 5x5 matrix SHALL require 25 elements.

Reset
REQ-037 While rst_n=0, the state SHALL be IDLE; wen, m, n, elem_in, elem_valid, busy, done and err_dim SHALL all be 0; the element and idle counters SHALL be 0.
REQ-038 Reset asserted mid-session SHALL abort immediately with no further wen or elem_valid; storage state recovery is outside this block.

Configuration
REQ-039 When MATRIX_INPUT_PAD_EN is defined, the PAD state, the idle counter and zero-padding SHALL be present as specified above.
REQ-040 When MATRIX_INPUT_PAD_EN is undefined, the PAD state and idle counter SHALL be absent, and DATA SHALL wait indefinitely for m*n bytes.

Verification
REQ-041 start; bytes 2,3,1,2,3,4,5,6 -> one wen pulse with m=2, n=3; six elem_valid pulses carrying 1..6; done pulse one cycle after input_done.
REQ-042 start; bytes 6,2 -> err_dim pulse, no wen, return to IDLE; repeat with 0,3 -> same result.
REQ-043 With PAD_EN and TIMEOUT_CYCLES=20: start; bytes 2,2,9; then silence -> elem 9 emitted, then 3 zero elements on consecutive cycles, then WAIT_DONE.
REQ-044 start; bytes 1,1, then a byte 7 in the OPEN cycle, then extra byte 8 -> single element 7 on the first DATA cycle; byte 8 ignored; done.
REQ-045 rst_n low during DATA of a 3x3 session after 4 elements -> all outputs 0 and state IDLE; a following 1x1 session with byte 5 completes normally.
REQ-046 start pulsed during DATA -> ignored; the session completes unchanged.
